pipe_hazard_irq_ctrl: RTL and testbench
=======================================

Name: pipe_hazard_irq_ctrl

Overview:
Parametrised successor to the current stall/flush logic of the 5-stage MIPS pipeline. It centralises per-stage stall and flush generation for these hazards:
- load-use
- branch-in-ID operand hazards
- multi-cycle EX busy
- ID-resolved redirects

It adds a precise external-interrupt sequencer with EPC capture and ERET return, driving the PC-select mux in IF. It sits beside the IF/ID/EX pipeline registers and replaces the scalar stall/flush pair with per-stage vectors.

Parameters:
NSTAGE, 5, number of pipeline stages (bit 0 = IF); must be >= 4
EX_IDX, 2, index of the EX stage; ID is EX_IDX-1; must satisfy 2 <= EX_IDX <= NSTAGE-2
REG_AW, 5, register address width
XLEN, 32, PC/data width
EXC_VEC, 32'h0000_0180, interrupt handler entry address

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
intterupt  in  1  level-sensitive external interrupt request
rs_id  in  REG_AW  rs of instruction in ID
rt_id  in  REG_AW  rt of instruction in ID
uses_rs_id  in  1  ID instruction reads rs
uses_rt_id  in  1  ID instruction reads rt
branch_id  in  1  ID instruction is a branch comparing in ID
redirect_id  in  1  taken branch/jump resolved in ID
eret_id  in  1  ERET in ID
pc_id  in  XLEN  PC of instruction in ID
mem_read_ex  in  1  load in EX
reg_write_ex  in  1  EX writes a register
rd_ex  in  REG_AW  EX destination register
mem_read_mem  in  1  load in MEM
rd_mem  in  REG_AW  MEM destination register
ex_busy  in  1  multi-cycle EX op not complete
stall  out  NSTAGE  bit i=1: hold stage i's register/PC
flush  out  NSTAGE  bit i=1: load a bubble into the register feeding stage i
pc_sel  out  2  0=PC+4, 1=redirect, 2=EXC_VEC, 3=EPC
epc  out  XLEN  saved return PC
int_ack  out  1  one-cycle interrupt acceptance pulse
in_handler  out  1  interrupt handler active; interrupts masked

Behaviour:
- Reset (synchronous, active-high) forces, registered on the next edge:
  - stall=0, flush=0, pc_sel=0, epc=0, int_ack=0, in_handler=0, FSM=IDLE.
- Reset overrides all other inputs.
- match(a) = (a != 0) && ((uses_rs_id && a == rs_id) || (uses_rt_id && a == rt_id)).
- Register $0 never causes a hazard.
- Hazard terms:
  - lu = mem_read_ex && match(rd_ex)
  - bh = branch_id && ((reg_write_ex && match(rd_ex)) || (mem_read_mem && match(rd_mem)))
- Priority, highest first, evaluated combinationally each cycle:
  1. ex_busy:
     - stall[0..EX_IDX] = 1, flush[EX_IDX+1] = 1.
     - Younger stages freeze; MEM receives a bubble.
     - All lower-priority actions are suppressed.
  2. lu or bh:
     - stall[0..EX_IDX-1] = 1, flush[EX_IDX] = 1.
     - Redirect, ERET and interrupt acceptance are suppressed this cycle; pc_sel = 0.
  3. Interrupt accept (FSM IDLE only, intterupt=1):
     - Requires redirect_id = 0 and eret_id = 0; otherwise acceptance is deferred to a later clean cycle.
     - Registered: epc <= pc_id; FSM -> VECTOR.
     - Same cycle: flush[EX_IDX] = 1 and flush[EX_IDX-1] = 1, killing the ID and IF instructions.
  4. eret_id in HANDLER:
     - pc_sel = 3, flush[EX_IDX-1] = 1.
     - Registered: in_handler <= 0; FSM -> IDLE.
  5. redirect_id: pc_sel = 1, flush[EX_IDX-1] = 1 (kills the wrong-path fetch).
- Bits of stall/flush not named above are 0.
- FSM states: IDLE, VECTOR, HANDLER.
  - VECTOR lasts exactly one cycle:
    - pc_sel = 2, int_ack = 1, flush[EX_IDX-1] = 1.
    - Registered: in_handler <= 1; -> HANDLER.
    - If ex_busy rises during VECTOR, FSM stays in VECTOR and the pc_sel/int_ack outputs are held until ex_busy falls; int_ack then pulses exactly once.
  - HANDLER: intterupt is ignored; only ERET exits.
  - eret_id outside HANDLER is treated as NOP (pc_sel = 0).
- epc changes only on interrupt acceptance.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=8, rs_id=8, uses_rs_id=1 -> stall=5'b00011, flush=5'b00100, pc_sel=0 for that cycle; rd_ex=0 with rs_id=0 -> no stall.
- Branch hazard: branch_id=1, reg_write_ex=1, rd_ex=9=rt_id, redirect_id=1 -> stall=5'b00011, flush=5'b00100, pc_sel=0; next cycle with hazard clear -> pc_sel=1, flush=5'b00010.
- ex_busy=1 for 3 cycles, load-use also present -> stall=5'b00111, flush=5'b01000 each cycle; pc_sel=0.
- Interrupt: intterupt=1, pc_id=32'h0040_0010, no hazards -> flush=5'b00110; next cycle pc_sel=2, int_ack=1 (one cycle only), epc=32'h0040_0010; then in_handler=1.
- In HANDLER, intterupt held high 10 cycles -> no further int_ack; eret_id=1 -> pc_sel=3, flush=5'b00010, in_handler=0 next cycle.
- intterupt with redirect_id=1 in the same cycle -> pc_sel=1, no accept; acceptance occurs next clean cycle. reset=1 mid-VECTOR -> all outputs 0 next edge, FSM IDLE.

Source files
------------

// File: rtl/pipe_hazard_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_irq_ctrl
// Brief    : Per-stage stall/flush generation and precise interrupt/ERET
//            sequencing for the in-order pipeline front end.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_irq_ctrl #(
    parameter int              NSTAGE  = 5,
    parameter int              EX_IDX  = 2,
    parameter int              REG_AW  = 5,
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] EXC_VEC = 32'h0000_0180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              intterupt,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              uses_rs_id,
    input  logic              uses_rt_id,
    input  logic              branch_id,
    input  logic              redirect_id,
    input  logic              eret_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic              mem_read_ex,
    input  logic              reg_write_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mem_read_mem,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              ex_busy,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic [1:0]        pc_sel,
    output logic [XLEN-1:0]   epc,
    output logic              int_ack,
    output logic              in_handler
);

    generate
        if (NSTAGE < 4 || EX_IDX < 2 || EX_IDX > NSTAGE - 2 || EXC_VEC[1:0] != 2'b00) begin : g_badParams
            $error("pipe_hazard_irq_ctrl: illegal parameter combination");
        end
    endgenerate

    localparam logic [NSTAGE-1:0] c_one       = NSTAGE'(1);
    localparam logic [NSTAGE-1:0] c_stallBusy = (c_one << (EX_IDX + 1)) - c_one;
    localparam logic [NSTAGE-1:0] c_stallHaz  = (c_one << EX_IDX) - c_one;
    localparam logic [NSTAGE-1:0] c_flushMem  = c_one << (EX_IDX + 1);
    localparam logic [NSTAGE-1:0] c_flushEx   = c_one << EX_IDX;
    localparam logic [NSTAGE-1:0] c_flushId   = c_one << (EX_IDX - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VECTOR  = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [XLEN-1:0]   r_epc;
    logic              r_inHandler;
    logic              w_accept;
    logic              w_matchEx;
    logic              w_matchMem;
    logic              w_luHazard;
    logic              w_brHazard;

    // Register $0 is hard-wired zero and can never be a producer.
    assign w_matchEx  = (rd_ex != '0) &&
                        ((uses_rs_id && rd_ex == rs_id) || (uses_rt_id && rd_ex == rt_id));
    assign w_matchMem = (rd_mem != '0) &&
                        ((uses_rs_id && rd_mem == rs_id) || (uses_rt_id && rd_mem == rt_id));
    assign w_luHazard = mem_read_ex && w_matchEx;
    assign w_brHazard = branch_id && ((reg_write_ex && w_matchEx) || (mem_read_mem && w_matchMem));

    always_comb begin
        stall       = '0;
        flush       = '0;
        pc_sel      = 2'd0;
        int_ack     = 1'b0;
        w_accept    = 1'b0;
        w_nextState = r_state;
        if (reset) begin
            w_nextState = ST_IDLE;
        end else if (ex_busy) begin
            // A pending vector waits here so int_ack fires once, after EX drains.
            stall = c_stallBusy;
            flush = c_flushMem;
        end else if (r_state == ST_VECTOR) begin
            pc_sel      = 2'd2;
            int_ack     = 1'b1;
            flush       = c_flushId;
            w_nextState = ST_HANDLER;
        end else if (w_luHazard || w_brHazard) begin
            stall = c_stallHaz;
            flush = c_flushEx;
        end else if (r_state == ST_IDLE && intterupt && !redirect_id && !eret_id) begin
            w_accept    = 1'b1;
            flush       = c_flushEx | c_flushId;
            w_nextState = ST_VECTOR;
        end else if (r_state == ST_HANDLER && eret_id) begin
            pc_sel      = 2'd3;
            flush       = c_flushId;
            w_nextState = ST_IDLE;
        end else if (redirect_id) begin
            pc_sel = 2'd1;
            flush  = c_flushId;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_epc       <= '0;
            r_inHandler <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_epc <= pc_id;
            end
            if (w_nextState == ST_HANDLER) begin
                r_inHandler <= 1'b1;
            end else if (w_nextState == ST_IDLE) begin
                r_inHandler <= 1'b0;
            end
        end
    end

    assign epc        = r_epc;
    assign in_handler = r_inHandler;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_irq_ctrl
// Brief    : Directed bench for pipe_hazard_irq_ctrl with a cycle model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_irq_ctrl;
    localparam int NSTAGE = 5;
    localparam int EX_IDX = 2;
    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int M_IDLE = 0;
    localparam int M_VEC  = 1;
    localparam int M_HND  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              intterupt;
    logic [REG_AW-1:0] rs_id, rt_id, rd_ex, rd_mem;
    logic              uses_rs_id, uses_rt_id, branch_id, redirect_id, eret_id;
    logic [XLEN-1:0]   pc_id;
    logic              mem_read_ex, reg_write_ex, mem_read_mem, ex_busy;
    logic [NSTAGE-1:0] stall, flush;
    logic [1:0]        pc_sel;
    logic [XLEN-1:0]   epc;
    logic              int_ack, in_handler;

    int nChecks = 0;
    int nFail   = 0;

    int              mMode = M_IDLE;
    logic [XLEN-1:0] mEpc  = '0;
    logic            mInh  = 1'b0;
    bit              modelValid = 1'b0;

    pipe_hazard_irq_ctrl #(
        .NSTAGE (NSTAGE),
        .EX_IDX (EX_IDX),
        .REG_AW (REG_AW),
        .XLEN   (XLEN),
        .EXC_VEC(32'h0000_0180)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .intterupt   (intterupt),
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .uses_rs_id  (uses_rs_id),
        .uses_rt_id  (uses_rt_id),
        .branch_id   (branch_id),
        .redirect_id (redirect_id),
        .eret_id     (eret_id),
        .pc_id       (pc_id),
        .mem_read_ex (mem_read_ex),
        .reg_write_ex(reg_write_ex),
        .rd_ex       (rd_ex),
        .mem_read_mem(mem_read_mem),
        .rd_mem      (rd_mem),
        .ex_busy     (ex_busy),
        .stall       (stall),
        .flush       (flush),
        .pc_sel      (pc_sel),
        .epc         (epc),
        .int_ack     (int_ack),
        .in_handler  (in_handler)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit regMatch(input logic [REG_AW-1:0] a);
        return (a != 0) && ((uses_rs_id && a == rs_id) || (uses_rt_id && a == rt_id));
    endfunction

    // Expected outputs for the current inputs and model mode.
    task automatic evalModel(output logic [NSTAGE-1:0] s, output logic [NSTAGE-1:0] f,
                             output logic [1:0] pc, output logic ack,
                             output int nm, output bit acc);
        bit lu, bh;
        s = '0; f = '0; pc = 2'd0; ack = 1'b0; nm = mMode; acc = 1'b0;
        lu = mem_read_ex && regMatch(rd_ex);
        bh = branch_id && ((reg_write_ex && regMatch(rd_ex)) || (mem_read_mem && regMatch(rd_mem)));
        if (reset) begin
            nm = M_IDLE;
        end else if (ex_busy) begin
            for (int i = 0; i <= EX_IDX; i++) s[i] = 1'b1;
            f[EX_IDX+1] = 1'b1;
        end else if (mMode == M_VEC) begin
            pc = 2'd2; ack = 1'b1; f[EX_IDX-1] = 1'b1; nm = M_HND;
        end else if (lu || bh) begin
            for (int i = 0; i < EX_IDX; i++) s[i] = 1'b1;
            f[EX_IDX] = 1'b1;
        end else if (mMode == M_IDLE && intterupt && !redirect_id && !eret_id) begin
            acc = 1'b1; f[EX_IDX] = 1'b1; f[EX_IDX-1] = 1'b1; nm = M_VEC;
        end else if (mMode == M_HND && eret_id) begin
            pc = 2'd3; f[EX_IDX-1] = 1'b1; nm = M_IDLE;
        end else if (redirect_id) begin
            pc = 2'd1; f[EX_IDX-1] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        logic [NSTAGE-1:0] s, f;
        logic [1:0]        pc;
        logic              ack;
        int                nm;
        bit                acc;
        evalModel(s, f, pc, ack, nm, acc);
        if (reset) begin
            mMode = M_IDLE; mEpc = '0; mInh = 1'b0; modelValid = 1'b1;
        end else begin
            if (acc) mEpc = pc_id;
            if (mMode == M_VEC && nm == M_HND) mInh = 1'b1;
            if (mMode == M_HND && nm == M_IDLE) mInh = 1'b0;
            mMode = nm;
        end
    end

    always @(negedge clk) begin
        logic [NSTAGE-1:0] s, f;
        logic [1:0]        pc;
        logic              ack;
        int                nm;
        bit                acc;
        if (modelValid) begin
            evalModel(s, f, pc, ack, nm, acc);
            chk("model_stall", 64'(stall), 64'(s));
            chk("model_flush", 64'(flush), 64'(f));
            chk("model_pc_sel", 64'(pc_sel), 64'(pc));
            chk("model_int_ack", 64'(int_ack), 64'(ack));
            chk("model_epc", 64'(epc), 64'(mEpc));
            chk("model_in_handler", 64'(in_handler), 64'(mInh));
        end
    end

    task automatic clearIn();
        intterupt = 0; rs_id = 0; rt_id = 0; uses_rs_id = 0; uses_rt_id = 0;
        branch_id = 0; redirect_id = 0; eret_id = 0; pc_id = 0;
        mem_read_ex = 0; reg_write_ex = 0; rd_ex = 0; mem_read_mem = 0; rd_mem = 0; ex_busy = 0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic exitHandler();
        clearIn(); eret_id = 1; settle();
        chk("eret_pc_sel", 64'(pc_sel), 64'd3);
        chk("eret_flush", 64'(flush), 64'b00010);
        adv(); clearIn(); settle();
        chk("eret_in_handler", 64'(in_handler), 64'd0);
    endtask

    initial begin
        clearIn();
        reset = 1;
        adv(); adv();
        settle();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_epc", 64'(epc), 64'd0);
        chk("rst_in_handler", 64'(in_handler), 64'd0);
        adv(); reset = 0;

        // Load-use on rs
        mem_read_ex = 1; rd_ex = 8; rs_id = 8; uses_rs_id = 1; settle();
        chk("lu_stall", 64'(stall), 64'b00011);
        chk("lu_flush", 64'(flush), 64'b00100);
        chk("lu_pc_sel", 64'(pc_sel), 64'd0);
        adv(); rd_ex = 0; rs_id = 0; settle();
        chk("lu_r0_stall", 64'(stall), 64'd0);

        // Branch hazard then redirect
        adv(); clearIn();
        branch_id = 1; reg_write_ex = 1; rd_ex = 9; rt_id = 9; uses_rt_id = 1; redirect_id = 1; settle();
        chk("bh_stall", 64'(stall), 64'b00011);
        chk("bh_flush", 64'(flush), 64'b00100);
        chk("bh_pc_sel", 64'(pc_sel), 64'd0);
        adv(); reg_write_ex = 0; settle();
        chk("redir_pc_sel", 64'(pc_sel), 64'd1);
        chk("redir_flush", 64'(flush), 64'b00010);

        // Branch hazard from a load in MEM
        adv(); clearIn();
        branch_id = 1; mem_read_mem = 1; rd_mem = 5; rs_id = 5; uses_rs_id = 1; settle();
        chk("bh_mem_stall", 64'(stall), 64'b00011);

        // ex_busy dominates load-use
        adv(); clearIn();
        mem_read_ex = 1; rd_ex = 8; rs_id = 8; uses_rs_id = 1; ex_busy = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("busy_stall", 64'(stall), 64'b00111);
            chk("busy_flush", 64'(flush), 64'b01000);
            chk("busy_pc_sel", 64'(pc_sel), 64'd0);
            adv();
        end

        // ERET outside handler is a NOP
        clearIn(); eret_id = 1; settle();
        chk("eret_idle_pc_sel", 64'(pc_sel), 64'd0);
        chk("eret_idle_flush", 64'(flush), 64'd0);

        // Interrupt acceptance and vector
        adv(); clearIn(); intterupt = 1; pc_id = 32'h0040_0010; settle();
        chk("acc_flush", 64'(flush), 64'b00110);
        adv(); settle();
        chk("vec_pc_sel", 64'(pc_sel), 64'd2);
        chk("vec_int_ack", 64'(int_ack), 64'd1);
        chk("vec_epc", 64'(epc), 64'h0040_0010);
        for (int i = 0; i < 10; i++) begin
            adv(); settle();
            chk("hnd_int_ack", 64'(int_ack), 64'd0);
            chk("hnd_in_handler", 64'(in_handler), 64'd1);
        end
        adv(); exitHandler();

        // Redirect defers acceptance
        adv(); intterupt = 1; redirect_id = 1; pc_id = 32'h0040_0020; settle();
        chk("defer_pc_sel", 64'(pc_sel), 64'd1);
        chk("defer_flush", 64'(flush), 64'b00010);
        adv(); redirect_id = 0; pc_id = 32'h0040_0024; settle();
        chk("defer_acc_flush", 64'(flush), 64'b00110);
        chk("defer_epc_old", 64'(epc), 64'h0040_0010);
        adv(); intterupt = 0; settle();
        chk("defer_int_ack", 64'(int_ack), 64'd1);
        chk("defer_epc", 64'(epc), 64'h0040_0024);
        adv(); exitHandler();

        // ex_busy during VECTOR holds the acknowledge off
        adv(); intterupt = 1; pc_id = 32'h0040_0030;
        adv(); intterupt = 0; ex_busy = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("vecbusy_int_ack", 64'(int_ack), 64'd0);
            chk("vecbusy_stall", 64'(stall), 64'b00111);
            adv();
        end
        ex_busy = 0; settle();
        chk("vecbusy_release_ack", 64'(int_ack), 64'd1);
        chk("vecbusy_release_pc", 64'(pc_sel), 64'd2);
        adv(); settle();
        chk("vecbusy_once", 64'(int_ack), 64'd0);
        adv(); exitHandler();

        // Reset in the middle of VECTOR
        adv(); intterupt = 1; pc_id = 32'h0040_0040;
        adv(); intterupt = 0; reset = 1;
        adv(); settle();
        chk("rstvec_epc", 64'(epc), 64'd0);
        chk("rstvec_in_handler", 64'(in_handler), 64'd0);
        chk("rstvec_pc_sel", 64'(pc_sel), 64'd0);
        adv(); reset = 0; settle();
        chk("rstvec_idle_ack", 64'(int_ack), 64'd0);
        chk("rstvec_idle_pc", 64'(pc_sel), 64'd0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
`default_nettype wire
